// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider (clkdiv_multi).
package clkdiv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    // Smallest legal divisor; a period needs at least one low and one high cycle.
    localparam int unsigned CFG_MIN_N = 2;

    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: active/shadow (N,H) config, modulo-N counter, registered output.
// CLKDIV_TICK_EN adds a registered period-boundary tick; otherwise tick is tied low.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEF_N = 3,
    parameter int DEF_H = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_n,
    input  logic [WIDTH-1:0] wr_h,
    output logic             clock_p,
    output logic             tick
);

    typedef struct packed {
        logic [WIDTH-1:0] n;
        logic [WIDTH-1:0] h;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{n: WIDTH'(DEF_N), h: WIDTH'(DEF_H)};

    chan_state_e      r_state;
    chan_state_e      w_state_nxt;
    cfg_t             r_act;
    cfg_t             w_act_nxt;
    cfg_t             r_shd;
    cfg_t             w_shd_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             r_clk;
    logic             w_clk_nxt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == (r_act.n - WIDTH'(1)));

    always_comb begin
        w_state_nxt = r_state;
        w_act_nxt   = r_act;
        w_shd_nxt   = r_shd;
        w_pend_nxt  = r_pend;
        w_cnt_nxt   = '0;
        w_clk_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend) begin
                    w_act_nxt  = r_shd;
                    w_pend_nxt = 1'b0;
                end
                if (enable) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_clk_nxt = (r_cnt >= (r_act.n - r_act.h));
                    if (w_wrap) begin
                        if (r_pend) begin
                            w_act_nxt  = r_shd;
                            w_pend_nxt = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + WIDTH'(1);
                    end
                end
            end
        endcase
        // Applied after the commit so a write landing on a wrap stays pending for the next one.
        if (wr_en) begin
            w_shd_nxt  = '{n: wr_n, h: wr_h};
            w_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_act   <= DEF_CFG;
            r_shd   <= DEF_CFG;
            r_pend  <= 1'b0;
            r_cnt   <= '0;
            r_clk   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_act   <= w_act_nxt;
            r_shd   <= w_shd_nxt;
            r_pend  <= w_pend_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clk   <= w_clk_nxt;
        end
    end

    assign clock_p = r_clk;

`ifdef CLKDIV_TICK_EN
    logic r_tick;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_state == RUN) && enable && w_wrap;
        end
    end

    assign tick = r_tick;
`else
    assign tick = 1'b0;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: config decode, cfg_err, and CHANNELS clkdiv_chan.
// Optional per-channel tick output is enabled by defining CLKDIV_TICK_EN.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int DEF_N    = 3,
    parameter int DEF_H    = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           enable,
    input  logic                          cfg_load,
    input  logic [ch_w(CHANNELS)-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]              cfg_n,
    input  logic [WIDTH-1:0]              cfg_h,
    output logic                          cfg_err,
    output logic [CHANNELS-1:0]           clock_p,
    output logic [CHANNELS-1:0]           tick
);

    localparam logic [31:0] CH_LIM = CHANNELS;

    logic                w_n_ok;
    logic                w_h_ok;
    logic                w_ch_ok;
    logic                w_accept;
    logic [CHANNELS-1:0] w_wr;
    logic                r_err;

    // H <= N-1 is written as H < N to avoid wrapping when N is 0.
    assign w_n_ok   = (cfg_n >= WIDTH'(CFG_MIN_N));
    assign w_h_ok   = (cfg_h != '0) && (cfg_h < cfg_n);
    assign w_ch_ok  = (32'(cfg_ch) < CH_LIM);
    assign w_accept = w_n_ok && w_h_ok && w_ch_ok;

    always_comb begin
        w_wr = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            w_wr[k] = cfg_load && w_accept && (32'(cfg_ch) == k);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= cfg_load && !w_accept;
        end
    end

    assign cfg_err = r_err;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        clkdiv_chan #(
            .WIDTH (WIDTH),
            .DEF_N (DEF_N),
            .DEF_H (DEF_H)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .enable  (enable[g]),
            .wr_en   (w_wr[g]),
            .wr_n    (cfg_n),
            .wr_h    (cfg_h),
            .clock_p (clock_p[g]),
            .tick    (tick[g])
        );
    end

endmodule
